// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write and read controllers: default
// geometry, the pointer type, and binary/Gray conversion helpers.
package fifo_pkg;

  localparam int DEPTH_DEF     = 8;
  localparam int PTR_WIDTH_DEF = 3;
  localparam int AF_MARGIN_DEF = 2;

  // One extra MSB beyond the address bits serves as the wrap bit
  typedef logic [PTR_WIDTH_DEF:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = '0;
    for (int i = 0; i <= PTR_WIDTH_DEF; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary converter of configurable width, shared
// by the write-side and read-side pointer controllers.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and status controller for the async FIFO (wclk domain).
// Optional almost-full status is built only when FIFO_WR_ALMOST_FULL_EN is defined.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr_sync,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic [PTR_WIDTH:0] wr_level,
  output logic               almost_full,
  output logic               overflow,
  output logic               overflow_sticky
);

  logic               wr_acc;
  logic [PTR_WIDTH:0] b_wptr_next;
  logic [PTR_WIDTH:0] g_wptr_next;
  logic [PTR_WIDTH:0] rptr_bin;
  logic [PTR_WIDTH:0] level_next;
  logic               full_next;

  // Empty marker block: only elaborated for an inconsistent parameter set
  if (DEPTH != (1 << PTR_WIDTH) || AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_illegal_params
  end

  gray2bin_conv #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_rptr_conv (
    .gray(g_rptr_sync),
    .bin (rptr_bin)
  );

  // Full compares against the read pointer with its top two Gray bits inverted,
  // i.e. exactly DEPTH entries ahead including the wrap bit
  always_comb begin
    wr_acc      = w_en & ~full;
    b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, wr_acc};
    g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);
    level_next  = b_wptr_next - rptr_bin;
    full_next   = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                   g_rptr_sync[PTR_WIDTH-2:0]});
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr          <= '0;
      g_wptr          <= '0;
      full            <= 1'b0;
      wr_level        <= '0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      b_wptr          <= b_wptr_next;
      g_wptr          <= g_wptr_next;
      full            <= full_next;
      wr_level        <= level_next;
      overflow        <= w_en & full;
      overflow_sticky <= overflow_sticky | (w_en & full);
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PTR_WIDTH:0] DEPTH_P  = DEPTH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] MARGIN_P = AF_MARGIN[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] free_next;

  assign free_next = DEPTH_P - level_next;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (free_next <= MARGIN_P);
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (DEPTH=8): reset, fill/overflow,
// drain-while-full and randomised wrap with a tracking read pointer.
module tb_fifo_wr_ctrl;

  localparam int PW = 3;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          w_en;
  logic [PW:0]   g_rptr_sync;
  logic [PW:0]   b_wptr;
  logic [PW:0]   g_wptr;
  logic          full;
  logic [PW:0]   wr_level;
  logic          almost_full;
  logic          overflow;
  logic          overflow_sticky;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic       full;
    logic [3:0] lvl;
    logic       af;
    logic       ovf;
    logic       sticky;
    logic       acc;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_w;
  logic       m_full;
  logic       m_sticky;
  logic [3:0] prev_g;
  logic [3:0] last_dut_b;
  logic       wrapped;
  int         accepts;

  always #5 wclk = ~wclk;

  fifo_wr_ctrl #(
    .DEPTH    (8),
    .PTR_WIDTH(3),
    .AF_MARGIN(2)
  ) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .w_en           (w_en),
    .g_rptr_sync    (g_rptr_sync),
    .b_wptr         (b_wptr),
    .g_wptr         (g_wptr),
    .full           (full),
    .wr_level       (wr_level),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .overflow_sticky(overflow_sticky)
  );

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w        = '0;
    m_full     = 1'b0;
    m_sticky   = 1'b0;
    prev_g     = '0;
    last_dut_b = '0;
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_b_wptr"}, 32'(b_wptr), 0);
    checkOutput({tag, "_g_wptr"}, 32'(g_wptr), 0);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_level"}, 32'(wr_level), 0);
    checkOutput({tag, "_af"}, 32'(almost_full), 0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    checkOutput({tag, "_sticky"}, 32'(overflow_sticky), 0);
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb_q.pop_front();
    checkOutput("b_wptr", 32'(b_wptr), 32'(e.b));
    checkOutput("g_wptr", 32'(g_wptr), 32'(e.g));
    checkOutput("full", 32'(full), 32'(e.full));
    checkOutput("wr_level", 32'(wr_level), 32'(e.lvl));
    checkOutput("almost_full", 32'(almost_full), 32'(e.af));
    checkOutput("overflow", 32'(overflow), 32'(e.ovf));
    checkOutput("overflow_sticky", 32'(overflow_sticky), 32'(e.sticky));
    checkOutput("gray_step", $countones(g_wptr ^ prev_g), 32'(e.acc));
    if (last_dut_b == 4'hF && b_wptr == 4'h0) wrapped = 1'b1;
    last_dut_b = b_wptr;
    prev_g     = e.g;
  endtask

  // Called just after a falling edge: drive inputs, predict the next edge, then compare
  task automatic applyStimulus(input logic we, input logic [3:0] rbin);
    exp_t       e;
    logic [3:0] lvl;
    w_en        = we;
    g_rptr_sync = to_gray(rbin);
    e.acc    = we && !m_full;
    e.b      = m_w + (e.acc ? 4'd1 : 4'd0);
    lvl      = e.b - rbin;
    e.g      = to_gray(e.b);
    e.lvl    = lvl;
    e.full   = (lvl == 4'd8);
`ifdef FIFO_WR_ALMOST_FULL_EN
    e.af     = (lvl >= 4'd6);
`else
    e.af     = 1'b0;
`endif
    e.ovf    = we && m_full;
    e.sticky = m_sticky | e.ovf;
    if (e.acc) accepts++;
    sb_q.push_back(e);
    m_w      = e.b;
    m_full   = e.full;
    m_sticky = e.sticky;
    @(posedge wclk);
    @(negedge wclk);
    compare_head();
  endtask

  initial begin
    logic [3:0] m_r;
    wrst_n      = 1'b0;
    w_en        = 1'b0;
    g_rptr_sync = '0;
    wrapped     = 1'b0;
    accepts     = 0;
    model_reset();
    #1;
    check_all_zero("por");
    @(negedge wclk);
    wrst_n = 1'b1;

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd0);
    #2 wrst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();

    $display("[TB] fill from empty with overflow");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'd0);
    checkOutput("fill_b_wptr", 32'(b_wptr), 32'h8);
    checkOutput("fill_g_wptr", 32'(g_wptr), 32'hC);
    checkOutput("fill_level", 32'(wr_level), 32'd8);

    $display("[TB] drain while full");
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd1);
    checkOutput("drain_b_wptr", 32'(b_wptr), 32'h9);
    applyStimulus(1'b0, 4'd2);
    applyStimulus(1'b0, 4'd3);

    $display("[TB] wrap with tracking read side");
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    model_reset();
    accepts = 0;
    m_r     = '0;
    for (int i = 0; i < 90; i++) begin
      if (((m_w - m_r) != 4'd0) && ($urandom_range(0, 1) == 1)) m_r = m_r + 4'd1;
      applyStimulus($urandom_range(0, 3) != 0, m_r);
    end
    checkOutput("wrap_seen", 32'(wrapped), 1);
    checkOutput("wrap_enough_accepts", 32'(accepts >= 40), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
